// File: rtl/rx_pkt_pkg.sv
// ============================================================================
// Module   : rx_pkt_pkg
// Purpose  : Shared types and constants for the receive packet tracker:
//            FSM state encoding, default geometry and saturating-counter
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_pkt_pkg;

    // Default geometry: 9-bit word counter, 8-entry descriptor queue.
    localparam int unsigned DEF_LEN_W = 9;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_PTR_W = 3;

    // Ceiling for the 8-bit event counters.
    localparam logic [7:0] CNT_SAT = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Increment that sticks at CNT_SAT instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == CNT_SAT) ? val : val + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_len_fifo.sv
// ============================================================================
// Module   : pkt_len_fifo
// Purpose  : Register-based circular FIFO holding completed packet lengths.
//            Wrapping read/write pointers plus an occupancy count separate
//            full from empty. The head output is registered and bypasses
//            the storage array when a push lands in the slot that will be
//            the head on the next cycle.
// Ports    : clk_i, reset_n_i      clock, async active-low reset
//            push_i, din_i         enqueue request and length
//            pop_i                 dequeue request (ignored when empty)
//            count_o               current occupancy
//            count_next_o          occupancy after this cycle's push/pop
//            head_o                oldest length, 0 when empty
//            full_o, empty_o       occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_len_fifo
    import rx_pkt_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTR_W = DEF_PTR_W
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [LEN_W-1:0] din_i,
    output logic [PTR_W:0]   count_o,
    output logic [PTR_W:0]   count_next_o,
    output logic [LEN_W-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [LEN_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [LEN_W-1:0] head_q, head_d;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == FULL_CNT);
    assign w_pop_ok  = pop_i & ~w_empty;
    // A simultaneous pop frees the slot, so a push into a full queue is legal.
    assign w_push_ok = push_i & (~w_full | w_pop_ok);

    always_comb begin
        wr_ptr_d = w_push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop_ok);
        head_d   = '0;
        if (count_d != '0) begin
            // The new head is the word being written this cycle when the
            // write slot coincides with the next read slot.
            if (w_push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = din_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_o       = head_q;
    assign full_o       = w_full;
    assign empty_o      = w_empty;

endmodule

`default_nettype wire

// File: rtl/rx_pkt_tracker.sv
// ============================================================================
// Module   : rx_pkt_tracker
// Purpose  : Tracks received packets written into the receive SRAM FIFO.
//            Counts 16-bit words per packet, queues lengths of packets that
//            complete with good CRC, and presents a level interrupt plus the
//            head packet length to the CPU-side controller.
// Ports    : clk_i, reset_n_i      clock, async active-low reset
//            pkt_start_i           new packet begins
//            wr_strobe_i           one word written
//            pkt_done_i            packet complete, good CRC
//            crc_rollback_i        packet failed CRC, discarded
//            cpu_ack_i             CPU consumed the head packet
//            irq_o                 high while any packet is queued
//            pkt_count_o           queued packet count
//            head_len_o            length of oldest queued packet
//            recv_busy_o           a packet is being received
//            drop_cnt_o            saturating dropped-packet count
//            rollback_cnt_o        saturating CRC-rollback count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_pkt_tracker
    import rx_pkt_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTR_W = DEF_PTR_W
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             pkt_start_i,
    input  logic             wr_strobe_i,
    input  logic             pkt_done_i,
    input  logic             crc_rollback_i,
    input  logic             cpu_ack_i,
    output logic             irq_o,
    output logic [PTR_W:0]   pkt_count_o,
    output logic [LEN_W-1:0] head_len_o,
    output logic             recv_busy_o,
    output logic [7:0]       drop_cnt_o,
    output logic [7:0]       rollback_cnt_o
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state_q;
    logic [LEN_W-1:0] cur_len_q;
    logic             len_ovf_q;
    logic [7:0]       drop_cnt_q;
    logic [7:0]       rollback_cnt_q;
    logic             irq_q;

    logic [LEN_W-1:0] w_len_upd;
    logic             w_ovf_upd;
    logic             w_in_recv;
    logic             w_rollback;
    logic             w_commit;
    logic             w_abort;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [PTR_W:0]   w_count_next;

    // Length including this cycle's strobe; a strobe at the ceiling marks
    // the packet as too long instead of wrapping.
    assign w_len_upd = (wr_strobe_i && (cur_len_q != LEN_MAX)) ? cur_len_q + LEN_W'(1)
                                                               : cur_len_q;
    assign w_ovf_upd = len_ovf_q | (wr_strobe_i & (cur_len_q == LEN_MAX));

    assign w_in_recv  = (state_q == RECV);
    assign w_rollback = w_in_recv & crc_rollback_i;
    assign w_commit   = w_in_recv & pkt_done_i & ~crc_rollback_i;
    assign w_abort    = w_in_recv & pkt_start_i & ~pkt_done_i & ~crc_rollback_i;

    assign w_pop  = cpu_ack_i & ~w_fifo_empty;
    assign w_push = w_commit & ~w_ovf_upd & (~w_fifo_full | w_pop);
    assign w_drop = (w_commit & ~w_push) | w_abort;

    pkt_len_fifo #(
        .LEN_W (LEN_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_len_fifo (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .push_i       (w_push),
        .pop_i        (cpu_ack_i),
        .din_i        (w_len_upd),
        .count_o      (pkt_count_o),
        .count_next_o (w_count_next),
        .head_o       (head_len_o),
        .full_o       (w_fifo_full),
        .empty_o      (w_fifo_empty)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            cur_len_q      <= '0;
            len_ovf_q      <= 1'b0;
            drop_cnt_q     <= '0;
            rollback_cnt_q <= '0;
            irq_q          <= 1'b0;
        end else begin
            irq_q <= (w_count_next != '0);
            if (w_drop) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            if (w_rollback) begin
                rollback_cnt_q <= sat_inc(rollback_cnt_q);
            end

            case (state_q)
                IDLE: begin
                    if (pkt_start_i) begin
                        state_q   <= RECV;
                        cur_len_q <= '0;
                        len_ovf_q <= 1'b0;
                    end
                end
                RECV: begin
                    if (crc_rollback_i || pkt_done_i) begin
                        state_q <= IDLE;
                    end else if (pkt_start_i) begin
                        // Aborted packet restarts from zero; the strobe in
                        // this cycle belongs to the abandoned packet.
                        cur_len_q <= '0;
                        len_ovf_q <= 1'b0;
                    end else begin
                        cur_len_q <= w_len_upd;
                        len_ovf_q <= w_ovf_upd;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_o          = irq_q;
    assign recv_busy_o    = w_in_recv;
    assign drop_cnt_o     = drop_cnt_q;
    assign rollback_cnt_o = rollback_cnt_q;

endmodule

`default_nettype wire

// File: doc/rx_pkt_tracker.md
Name: rx_pkt_tracker

Overview:
- Sits directly downstream of Wireless_Ctrl, on the receive path into FIFO_O.
- Watches packet-start, per-word SRAM write, packet-done and CRC-rollback events, and counts 16-bit words per packet.
- Queues completed packet lengths in a small descriptor FIFO.
- Drives a level interrupt and head-of-queue length to Slave_Ctrl, so the CPU knows how many whole packets sit in FIFO_O and how long the next one is.

Parameters:
LEN_W, 9, width of word-length counter; max packet 2^LEN_W-1 words
DEPTH, 8, descriptor FIFO entries (power of two)
PTR_W, 3, log2(DEPTH)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pkt_start  in  1  1-cycle pulse, Wireless_Ctrl began writing a new received packet
wr_strobe  in  1  1-cycle pulse per 16-bit word written to FIFO_O by the wireless side
pkt_done  in  1  1-cycle pulse, packet completed with good CRC
crc_rollback  in  1  1-cycle pulse, packet failed CRC; SRAM pointer rolled back
cpu_ack  in  1  1-cycle pulse from Slave_Ctrl, CPU fully read the head packet
irq  out  1  registered, high while pkt_count != 0
pkt_count  out  PTR_W+1  number of queued complete packets
head_len  out  LEN_W  word length of oldest queued packet; 0 when queue empty
recv_busy  out  1  high in RECV state
drop_cnt  out  8  saturating count of packets dropped (queue full or length overflow)
rollback_cnt  out  8  saturating count of CRC rollbacks

Behaviour:
- Reset: state=IDLE; cur_len, pointers, pkt_count, head_len, irq, recv_busy, drop_cnt, rollback_cnt all 0. Reset mid-packet discards everything.
- FSM states:
  - IDLE: pkt_start -> RECV, cur_len<=0. wr_strobe, pkt_done and crc_rollback are ignored in IDLE.
  - RECV: each wr_strobe does cur_len+1. On reaching 2^LEN_W-1, cur_len saturates and len_ovf latches.
- Exit from RECV, in priority order:
  1. crc_rollback: discard, rollback_cnt+1 (saturating at 255), -> IDLE.
  2. pkt_done: commit, -> IDLE.
  3. pkt_start: abort the current packet, counted in drop_cnt; restart with cur_len<=0, stay RECV.
- Same-cycle wr_strobe with pkt_done: that word is included, so committed length = cur_len+1.
- Commit rules:
  - Push when queue not full and no len_ovf.
  - Otherwise drop_cnt+1 (saturating); no push.
  - Zero-length commits are pushed.
- Descriptor FIFO:
  - Circular buffer, PTR_W-bit wrapping pointers plus pkt_count to distinguish full from empty.
  - Push and pop in the same cycle: both performed, pkt_count unchanged. Push is allowed in that cycle even when full, because the pop frees an entry.
  - cpu_ack when empty is ignored: no underflow, count stays 0.
- Latency: pushed entry visible on pkt_count, head_len and irq the cycle after pkt_done. Pop is visible the cycle after cpu_ack.
- head_len is registered: equals mem[rd_ptr] when count>0, else 0. On push into an empty queue, head_len takes the pushed value directly (bypass).
- irq is registered: irq <= (next pkt_count != 0).
- recv_busy is a combinational decode of state.

Decomposition:
- Shared package rx_pkt_pkg holds:
  - FSM state encoding: IDLE=1'b0, RECV=1'b1.
  - Default LEN_W/DEPTH constants.
  - CNT_SAT=8'hFF.
- One sub-module, pkt_len_fifo: parameterised DEPTH x LEN_W register-based FIFO with push, pop, count, head and full/empty. rx_pkt_tracker instantiates it and owns the FSM and counters.

Test Plan:
- Basic packet: pkt_start, 5 wr_strobe, pkt_done -> next cycle pkt_count=1, head_len=5, irq=1. Then cpu_ack -> next cycle pkt_count=0, head_len=0, irq=0.
- CRC rollback: pkt_start, 7 wr_strobe, crc_rollback -> pkt_count stays 0, rollback_cnt=1, state IDLE. A following good packet of 3 words gives head_len=3.
- Queue full and simultaneous events:
  - Commit 8 packets of lengths 1..8 -> pkt_count=8.
  - 9th packet -> drop_cnt=1, count stays 8.
  - 10th packet with pkt_done coinciding with cpu_ack -> count stays 8, head_len=2.
- Same-cycle edge cases:
  - wr_strobe and pkt_done on the same cycle after 4 strobes -> head_len=5.
  - crc_rollback and pkt_done together -> rollback wins, no push.
- Overflow and restart:
  - LEN_W=4 build, 16 strobes then pkt_done -> drop_cnt=1, no push.
  - pkt_start during RECV -> drop_cnt increments, new packet length counts from 0.
- Async reset mid-RECV with 2 packets queued -> all outputs 0 immediately. cpu_ack while empty -> no change.
